vga_tx_timing: RTL
==================

# vga_tx_timing

Pixel-stream transmitter for the 640x480@60 Hz VGA output. It divides the 50 MHz system clock to a 25 MHz pixel rate and generates horizontal/vertical counters and sync pulses. It requests one RGB pixel per pixel period from the frame renderer through `pixel_x`/`pixel_y`, and drives the registered, blank-masked colour and sync lines to the DAC pins. It sits between the world/robot renderer and the top-level `VGA_*` ports, and is the source of the `pixel_x`/`pixel_y` scan that frame-capture benches sample.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BACK`, 33, vertical back porch

Ports:
- `clock` in 1: 50 MHz system clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high reset
- `rgb_in` in 24: `{r[7:0],g[7:0],b[7:0]}` for the pixel addressed by `pixel_x`/`pixel_y`
- `pixel_x` out 10: current horizontal count, 0..799
- `pixel_y` out 10: current vertical count, 0..524
- `pix_en` out 1: one-clock strobe marking the last clock of a pixel period
- `line_start` out 1: one-clock pulse when `pixel_x` becomes 0
- `frame_start` out 1: one-clock pulse when (`pixel_x`,`pixel_y`) becomes (0,0)
- `vga_clk` out 1: 25 MHz pixel clock, equal to `pix_en`
- `vga_hs`, `vga_vs` out 1: sync outputs, active-low
- `vga_blank_n` out 1: high while the DAC output is in the visible area
- `vga_r`, `vga_g`, `vga_b` out 8: colour outputs
- `frame_count` out 16: completed-frame counter (see Configuration)

## Operation
- Pixel enable: a 1-bit toggle; 0 in the first clock after reset, then alternating. Each pixel period is 2 clocks.
- Counters advance only on clocks with `pix_en`=1.
  - `pixel_x` wraps from 799 to 0 and increments `pixel_y` on the same clock.
  - `pixel_y` wraps from 524 to 0.
- Visible region: `pixel_x`<640 and `pixel_y`<480.
- Sync decode from the counters:
  - hsync is active for `pixel_x` in 656..751.
  - vsync is active for `pixel_y` in 490..491.
- Output stage: on a `pix_en` clock, `rgb_in` (masked to 0 outside the visible region), the sync decodes and the blank decode for the current counters are registered into `vga_r/g/b`, `vga_hs`, `vga_vs`, `vga_blank_n`. The DAC pins therefore lag the coordinates by exactly one pixel period.
- `line_start` and `frame_start` assert on the clock after the counter update that produced x=0 or (0,0). They last one clock only; `frame_start` implies `line_start`.
- `rgb_in` is sampled only on `pix_en` clocks; changes between strobes are ignored.
- Reset, including reset in mid-line or mid-frame:
  - counters 0, toggle 0
  - `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, `vga_r/g/b`=0
  - `line_start`=`frame_start`=0, `frame_count`=0
- No pulses occur in the reset clock itself.

## Timing
- Line = 800 pixels = 1600 clocks. Frame = 525 lines = 840,000 clocks.
- After reset deasserts, the first `pix_en` is at clock 1 and `pixel_x` reaches 1 after clock 1.
- Coordinate-to-pin latency is 1 pixel period (2 clocks). The renderer must present `rgb_in` combinationally or within 1 clock of the coordinate change.
- `vga_hs` first goes low 2 clocks after `pixel_x` becomes 656.
- Counter wrap and the `pixel_y` increment happen on the same edge, so no extra cycle is inserted at line end.

## Configuration
- `VGA_FRAME_COUNT_EN`:
  - Defined: `frame_count` increments (mod 2^16) on every `frame_start`.
  - Undefined: the counter logic is removed and `frame_count` is tied to 0.
- Sync and pixel behaviour are identical either way.

## Structure
- A shared package `vga_pkg` holds the 640x480 timing constants, the total counts (800, 525), the sync start/end values derived from them, and the packed-RGB width (24).
- One sub-module, `vga_axis_counter`: a modulo counter with an enable, a wrap-out, and sync/visible window compares. It is instantiated twice, horizontal (enabled by `pix_en`) and vertical (enabled by horizontal wrap).

## Test plan
- Reset release, `rgb_in`=24'hFFFFFF:
  - `pixel_x` counts 0,0,1,1,2,…
  - `vga_r`=255 from clock 2 to clock 1281
  - `vga_r`=0 and `vga_blank_n`=0 from x=640 onward
- Full line:
  - `line_start` pulses every 1600 clocks
  - `vga_hs` is low for exactly 192 clocks, starting 2 clocks after x=656
- Full frame:
  - `frame_start` pulses every 840,000 clocks
  - `vga_vs` is low for exactly 3200 clocks (lines 490–491 delayed 2 clocks)
  - with `VGA_FRAME_COUNT_EN`, `frame_count`=1 then 2
- Wrap corner:
  - at (799,524), the next `pix_en` yields (0,0)
  - `frame_start` and `line_start` both pulse 1 clock later
- Reset asserted at (300,200) for 1 clock:
  - the next clock shows all outputs at reset values
  - the scan restarts at (0,0)
  - the first `frame_start` occurs 840,000 clocks later
- Bench: frame capture of the `rgb_in`=`{pixel_x[7:0],pixel_y[7:0],8'h00}` pattern produces 640x480 pixels whose colour equals their coordinate.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, derived totals/sync windows and pixel types
// for the VGA transmitter slice.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int RGB_W         = 24;
    localparam int COORD_W       = 10;
    localparam int FRAME_COUNT_W = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_tx_timing_if.sv
// Renderer-side scan/pixel signals and DAC pins of the VGA transmitter.
// master = timing generator, slave = renderer / pin consumer.
interface vga_tx_timing_if;
    import vga_pkg::*;

    logic [RGB_W-1:0]         rgb_in;
    logic [COORD_W-1:0]       pixel_x;
    logic [COORD_W-1:0]       pixel_y;
    logic                     pix_en;
    logic                     line_start;
    logic                     frame_start;
    logic                     vga_clk;
    logic                     vga_hs;
    logic                     vga_vs;
    logic                     vga_blank_n;
    logic [7:0]               vga_r;
    logic [7:0]               vga_g;
    logic [7:0]               vga_b;
    logic [FRAME_COUNT_W-1:0] frame_count;

    modport master (
        input  rgb_in,
        output pixel_x, pixel_y, pix_en, line_start, frame_start, vga_clk,
               vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_count
    );

    modport slave (
        output rgb_in,
        input  pixel_x, pixel_y, pix_en, line_start, frame_start, vga_clk,
               vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_count
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: modulo counter with enable, wrap-out, and visible/sync window decodes.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int VISIBLE    = VGA_H_VISIBLE,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_END   = VGA_H_SYNC_END
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               visible,
    output logic               sync_active
);

    localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] VIS_END  = COORD_W'(VISIBLE);
    localparam logic [COORD_W-1:0] SYNC_LO  = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SYNC_HI  = COORD_W'(SYNC_END);

    // Wrap is qualified by enable so the next axis can use it directly as its step.
    assign wrap        = enable && (count == LAST);
    assign visible     = count < VIS_END;
    assign sync_active = (count >= SYNC_LO) && (count <= SYNC_HI);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_tx_timing.sv
// VGA pixel-stream transmitter: 2-clock pixel strobe, H/V scan, registered DAC stage.
// Optional completed-frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_tx_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic            clock,
    input  logic            reset,
    vga_tx_timing_if.master vga
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic               pix_en;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               h_wrap, v_wrap;
    logic               h_visible, v_visible;
    logic               h_sync, v_sync;
    logic               visible;
    rgb_t               rgb_masked;

    rgb_t               rgb_q;
    logic               hs_q, vs_q, blank_n_q;
    logic               line_start_q, frame_start_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
        .SYNC_START(H_SYNC_START), .SYNC_END(H_SYNC_END)
    ) u_h_axis (
        .clock(clock), .reset(reset), .enable(pix_en),
        .count(h_count), .wrap(h_wrap), .visible(h_visible), .sync_active(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
        .SYNC_START(V_SYNC_START), .SYNC_END(V_SYNC_END)
    ) u_v_axis (
        .clock(clock), .reset(reset), .enable(h_wrap),
        .count(v_count), .wrap(v_wrap), .visible(v_visible), .sync_active(v_sync)
    );

    assign visible    = h_visible && v_visible;
    assign rgb_masked = visible ? rgb_t'(vga.rgb_in) : '0;

    // Pins capture the decode of the current coordinates, so they trail them by one pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (pix_en) begin
                rgb_q     <= rgb_masked;
                hs_q      <= ~h_sync;
                vs_q      <= ~v_sync;
                blank_n_q <= visible;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_COUNT_W-1:0] frame_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (v_wrap) begin
            frame_count_q <= frame_count_q + 1'b1;
        end
    end

    assign vga.frame_count = frame_count_q;
`else
    assign vga.frame_count = '0;
`endif

    assign vga.pixel_x     = h_count;
    assign vga.pixel_y     = v_count;
    assign vga.pix_en      = pix_en;
    assign vga.vga_clk     = pix_en;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vga_hs      = hs_q;
    assign vga.vga_vs      = vs_q;
    assign vga.vga_blank_n = blank_n_q;
    assign vga.vga_r       = rgb_q.r;
    assign vga.vga_g       = rgb_q.g;
    assign vga.vga_b       = rgb_q.b;

endmodule
